// File: rtl/ysyx_25040105_lsu_if.sv
// Execute/memory/write-back bundle for the LSU. The slave modport is the LSU's view;
// the master modport is the view of whatever surrounds it.
interface ysyx_25040105_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [4:0]        in_rd;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_wen;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic [DATA_W/8-1:0] mem_req_wmask;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_rd;
    logic              out_wen;
    logic              out_err;

    modport slave (
        input  in_valid, in_op, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
        output in_ready, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output out_valid, out_data, out_rd, out_wen, out_err
    );

    modport master (
        output in_valid, in_op, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
        input  in_ready, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  out_valid, out_data, out_rd, out_wen, out_err
    );
endinterface

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: one operation in flight, request/response memory port,
// valid/ready hand-off of the extended result to write-back.
module ysyx_25040105_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_25040105_lsu_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;

    logic              in_mem, in_misal;
    logic [DATA_W-1:0] rsp_sh, load_ext, st_wdata;
    logic [15:0]       rsp_half;
    logic [3:0]        st_wmask;

    assign in_mem   = (bus.in_op == 2'b01) || (bus.in_op == 2'b10);
    assign in_misal = ((bus.in_size == 2'b01) && bus.in_addr[0]) ||
                      (bus.in_size[1] && (bus.in_addr[1:0] != 2'b00));

    assign rsp_sh   = bus.mem_rsp_rdata >> {addr_q[1:0], 3'b000};
    assign rsp_half = addr_q[1] ? bus.mem_rsp_rdata[31:16] : bus.mem_rsp_rdata[15:0];

    always_comb begin
        load_ext = bus.mem_rsp_rdata;
        st_wdata = wdata_q;
        st_wmask = 4'b1111;
        case (size_q)
            2'b00: begin
                load_ext = {{24{~uns_q & rsp_sh[7]}}, rsp_sh[7:0]};
                st_wdata = {4{wdata_q[7:0]}};
                st_wmask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                load_ext = {{16{~uns_q & rsp_half[15]}}, rsp_half};
                st_wdata = {2{wdata_q[15:0]}};
                st_wmask = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wen_d   = wen_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                store_d = (bus.in_op == 2'b10);
                size_d  = bus.in_size;
                uns_d   = bus.in_unsigned;
                addr_d  = bus.in_addr;
                wdata_d = bus.in_wdata;
                rd_d    = bus.in_rd;
                data_d  = '0;
                wen_d   = 1'b0;
                err_d   = 1'b0;
                if (!in_mem) begin
                    data_d  = bus.in_wdata;
                    wen_d   = (bus.in_rd != 5'd0);
                    state_d = DONE;
                end else if (in_misal) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: if (bus.mem_req_ready) state_d = WAIT;
            // Store responses are bare acks; only loads produce write-back data.
            WAIT: if (bus.mem_rsp_valid) begin
                state_d = DONE;
                data_d  = store_q ? '0 : load_ext;
                wen_d   = !store_q && (rd_q != 5'd0);
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
        end
    end

    logic in_req, in_done;
    assign in_req  = (state_q == REQ);
    assign in_done = (state_q == DONE);

    // Outputs are gated by state so everything reads zero while the unit is idle.
    assign bus.in_ready      = (state_q == IDLE);
    assign bus.mem_req_valid = in_req;
    assign bus.mem_req_wen   = in_req && store_q;
    assign bus.mem_req_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_req_wdata = (in_req && store_q) ? st_wdata : '0;
    assign bus.mem_req_wmask = (in_req && store_q) ? st_wmask : 4'b0000;
    assign bus.out_valid     = in_done;
    assign bus.out_data      = in_done ? data_q : '0;
    assign bus.out_rd        = in_done ? rd_q : 5'd0;
    assign bus.out_wen       = in_done && wen_q;
    assign bus.out_err       = in_done && err_q;
endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Directed bench for the LSU: a reactive memory, a result model built from the
// addressing/extension rules, and a per-cycle compare against that model.
module tb_ysyx_25040105_lsu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25040105_lsu_if bus ();
    ysyx_25040105_lsu dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    bit busy   = 0;

    // Expectation for the operation currently in flight.
    bit          exp_mem, e_req_wen, e_wen, e_err, e_chk_data;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_wmask;
    logic [4:0]  e_rd;

    // What the driver saw, for the hand-computed literal checks.
    bit          saw_req, cap_req_wen, cap_wen, cap_err;
    logic [31:0] cap_req_addr, cap_wdata, cap_data;
    logic [3:0]  cap_wmask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_expect(input logic [1:0] op, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata);
        bit misal;
        int m;
        longint v;
        misal      = ((size == 2'd1) && (addr % 2 != 0)) || ((size >= 2'd2) && (addr % 4 != 0));
        exp_mem    = (op == 2'd1 || op == 2'd2) && !misal;
        e_addr     = addr & 32'hFFFF_FFFC;
        e_req_wen  = (op == 2'd2);
        e_rd       = rd;
        e_err      = (op == 2'd1 || op == 2'd2) && misal;
        e_chk_data = !e_err;
        if (size == 2'd0) begin
            e_wdata = {24'd0, wdata[7:0]} * 32'h0101_0101;
            m = 1 << (addr % 4);
        end else if (size == 2'd1) begin
            e_wdata = {16'd0, wdata[15:0]} * 32'h0001_0001;
            m = 3 << ((addr % 4) & 2);
        end else begin
            e_wdata = wdata;
            m = 15;
        end
        e_wmask = (op == 2'd2) ? m[3:0] : 4'd0;
        if (op == 2'd0 || op == 2'd3) begin
            e_data = wdata;
            e_wen  = (rd != 0);
        end else if (misal) begin
            e_data = 32'd0;
            e_wen  = 0;
        end else if (op == 2'd2) begin
            e_data = 32'd0;
            e_wen  = 0;
        end else begin
            if (size == 2'd0) begin
                v = (rdata >> (8 * (addr % 4))) & 32'hFF;
                if (!uns && v >= 128) v = v - 256;
            end else if (size == 2'd1) begin
                v = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
                if (!uns && v >= 32768) v = v - 65536;
            end else begin
                v = rdata;
            end
            e_data = v[31:0];
            e_wen  = (rd != 0);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("in_ready", bus.in_ready, !busy);
        if (!busy) begin
            chk("idle mem_req_valid", bus.mem_req_valid, 0);
            chk("idle out_valid", bus.out_valid, 0);
        end else begin
            if (!exp_mem) chk("unexpected mem_req_valid", bus.mem_req_valid, 0);
            else if (bus.mem_req_valid) begin
                chk("req_addr", bus.mem_req_addr, e_addr);
                chk("req_wen", bus.mem_req_wen, e_req_wen);
                chk("req_wmask", bus.mem_req_wmask, e_wmask);
                if (e_req_wen) chk("req_wdata", bus.mem_req_wdata, e_wdata);
            end
            if (bus.out_valid) begin
                chk("out_rd", bus.out_rd, e_rd);
                chk("out_wen", bus.out_wen, e_wen);
                chk("out_err", bus.out_err, e_err);
                if (e_chk_data) chk("out_data", bus.out_data, e_data);
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int stall, input int delay,
                         input int hold, input bit junk);
        int  cyc, st, dl, lat;
        bit  waiting, hs, reqv, fired;
        set_expect(op, size, uns, addr, wdata, rd, rdata);
        lat = exp_mem ? 3 + stall + delay : 1;
        saw_req = 0;
        chk("in_ready before issue", bus.in_ready, 1);
        bus.in_valid    = 1;
        bus.in_op       = op;
        bus.in_size     = size;
        bus.in_unsigned = uns;
        bus.in_addr     = addr;
        bus.in_wdata    = wdata;
        bus.in_rd       = rd;
        @(posedge clk);
        busy = 1;
        #1;
        bus.in_valid = 0;
        bus.in_wdata = 32'h5555_5555;
        cyc = 1; st = stall; dl = 0; waiting = 0;
        while (!bus.out_valid && cyc < 100) begin
            reqv = bus.mem_req_valid;
            bus.mem_req_ready = reqv && (st == 0);
            fired = waiting && (dl == 0);
            if (fired) begin
                bus.mem_rsp_valid = 1;
                bus.mem_rsp_rdata = rdata;
            end else begin
                bus.mem_rsp_valid = junk && !waiting;
                bus.mem_rsp_rdata = 32'hDEAD_BEEF;
            end
            hs = reqv && bus.mem_req_ready;
            if (reqv) begin
                saw_req      = 1;
                cap_req_addr = bus.mem_req_addr;
                cap_req_wen  = bus.mem_req_wen;
                cap_wdata    = bus.mem_req_wdata;
                cap_wmask    = bus.mem_req_wmask;
            end
            @(posedge clk);
            if (hs) begin
                waiting = 1;
                dl = delay;
            end else if (reqv) st--;
            else if (fired) waiting = 0;
            else if (waiting) dl--;
            #1;
            cyc++;
        end
        bus.mem_req_ready = 0;
        bus.mem_rsp_valid = junk;
        chk("out_valid seen", bus.out_valid, 1);
        chk("latency", cyc, lat);
        cap_data = bus.out_data;
        cap_wen  = bus.out_wen;
        cap_err  = bus.out_err;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1;
        @(posedge clk);
        busy = 0;
        #1;
        bus.out_ready     = 0;
        bus.mem_rsp_valid = 0;
    endtask

    initial begin
        rst = 1;
        bus.in_valid = 0; bus.in_op = 0; bus.in_size = 0; bus.in_unsigned = 0;
        bus.in_addr = 0; bus.in_wdata = 0; bus.in_rd = 0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst mem_req_valid", bus.mem_req_valid, 0);
        chk("rst mem_req_wmask", bus.mem_req_wmask, 0);
        chk("rst mem_req_addr", bus.mem_req_addr, 0);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst out_wen", bus.out_wen, 0);
        rst = 0;
        chk_en = 1;

        do_op(2'd0, 2'd2, 0, 32'h0, 32'h1234_5678, 5'd5, 32'h0, 0, 0, 0, 0);
        chk("tp pass data", cap_data, 32'h1234_5678);
        chk("tp pass wen", cap_wen, 1);
        do_op(2'd0, 2'd2, 0, 32'h0, 32'h1234_5678, 5'd0, 32'h0, 0, 0, 1, 0);
        chk("tp pass rd0 wen", cap_wen, 0);
        do_op(2'd3, 2'd1, 0, 32'h3, 32'hCAFE_0001, 5'd3, 32'h0, 0, 0, 0, 1);
        chk("reserved op data", cap_data, 32'hCAFE_0001);

        do_op(2'd1, 2'd0, 0, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_0000, 0, 2, 0, 0);
        chk("tp lb addr", cap_req_addr, 32'h8000_0000);
        chk("tp lb wmask", cap_wmask, 4'b0000);
        chk("tp lb data", cap_data, 32'hFFFF_FF80);
        do_op(2'd1, 2'd0, 1, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_0000, 0, 2, 0, 1);
        chk("tp lbu data", cap_data, 32'h0000_0080);

        do_op(2'd2, 2'd1, 0, 32'h8000_0006, 32'hAAAA_BEEF, 5'd9, 32'h0, 0, 0, 0, 0);
        chk("tp sh wen", cap_req_wen, 1);
        chk("tp sh wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("tp sh wmask", cap_wmask, 4'b1100);
        chk("tp sh out_wen", cap_wen, 0);

        do_op(2'd1, 2'd2, 0, 32'h8000_0002, 32'h0, 5'd4, 32'h0, 0, 0, 0, 1);
        chk("tp misal req", saw_req, 0);
        chk("tp misal err", cap_err, 1);
        chk("tp misal wen", cap_wen, 0);

        do_op(2'd2, 2'd2, 0, 32'h8000_0010, 32'h1122_3344, 5'd2, 32'h0, 3, 1, 4, 1);
        chk("bp sw wdata", cap_wdata, 32'h1122_3344);
        do_op(2'd1, 2'd1, 0, 32'h0000_0002, 32'h0, 5'd8, 32'h8001_7FFF, 1, 0, 2, 0);
        chk("lh hi data", cap_data, 32'hFFFF_8001);
        do_op(2'd1, 2'd1, 1, 32'h0000_0000, 32'h0, 5'd8, 32'h8001_7FFF, 0, 3, 0, 1);
        chk("lhu lo data", cap_data, 32'h0000_7FFF);
        do_op(2'd2, 2'd0, 0, 32'h0000_0101, 32'h0000_005A, 5'd1, 32'h0, 0, 0, 0, 0);
        chk("sb wmask", cap_wmask, 4'b0010);
        do_op(2'd1, 2'd2, 0, 32'h0000_0040, 32'h0, 5'd0, 32'hF00D_1234, 0, 0, 0, 0);
        do_op(2'd1, 2'd3, 0, 32'h0000_0044, 32'h0, 5'd31, 32'h8765_4321, 2, 0, 1, 0);
        chk("size3 word data", cap_data, 32'h8765_4321);
        do_op(2'd1, 2'd1, 1, 32'h0000_0001, 32'h0, 5'd6, 32'h0, 0, 0, 0, 0);
        do_op(2'd2, 2'd1, 0, 32'h0000_0003, 32'hFFFF_FFFF, 5'd6, 32'h0, 0, 0, 0, 0);
        chk("sh misal err", cap_err, 1);

        // Abort a load while it waits for its response.
        chk_en = 0;
        bus.in_valid = 1; bus.in_op = 2'd1; bus.in_size = 2'd2; bus.in_unsigned = 0;
        bus.in_addr = 32'h8000_0020; bus.in_rd = 5'd10;
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.mem_req_ready = 1;
        chk("abort in REQ", bus.mem_req_valid, 1);
        @(posedge clk); #1;
        bus.mem_req_ready = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort in_ready", bus.in_ready, 1);
        chk("abort mem_req_valid", bus.mem_req_valid, 0);
        chk("abort out_valid", bus.out_valid, 0);
        bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 0;
        chk("late rsp out_valid", bus.out_valid, 0);
        chk("late rsp in_ready", bus.in_ready, 1);
        chk_en = 1;
        do_op(2'd0, 2'd2, 0, 32'h0, 32'h0BAD_F00D, 5'd12, 32'h0, 0, 0, 0, 0);
        chk("post-abort pass data", cap_data, 32'h0BAD_F00D);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
